// File: rtl/wca_synch_filter.sv
// Multi-channel level synchronizer with registered edge pulses and an optional
// per-channel persistence filter, compiled in when WCA_SYNCH_FILTER_EN is defined.
module wca_synch_filter #(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] INIT       = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             changed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= INIT;
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[STAGES-1];

`ifdef WCA_SYNCH_FILTER_EN
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    // A channel's count runs only while s disagrees with out; it saturates by
    // committing the new level on the terminal value, so it can never wrap.
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    out_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= INIT;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q <= out_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    // Unfiltered, the last synchronizer stage is the output register itself.
    assign out_q = s;
    assign out_d = sync_q[STAGES-2];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= out_d & ~out_q;
            fall_q    <= ~out_d & out_q;
            changed_q <= |(out_d ^ out_q);
        end
    end

    assign out     = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_wca_synch_filter.sv
// Directed bench for wca_synch_filter; expectations follow the build's filter setting.
module tb_wca_synch_filter;

`ifdef WCA_SYNCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT0 = FILT ? (2 + 4) : 2;
    localparam int LAT1 = FILT ? (3 + 1) : 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in0 = 4'h0;
    logic [3:0] in1 = 4'h0;
    logic [3:0] out0, rise0, fall0;
    logic [3:0] out1, rise1, fall1;
    logic       changed0, changed1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] hist [0:31];

    wca_synch_filter #(.WIDTH(4), .STAGES(2), .FILTER_LEN(4), .INIT(4'h0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in(in0),
        .out(out0), .rise(rise0), .fall(fall0), .changed(changed0)
    );

    wca_synch_filter #(.WIDTH(4), .STAGES(3), .FILTER_LEN(1), .INIT(4'hF)) dut1 (
        .clk(clk), .reset_n(reset_n), .in(in1),
        .out(out1), .rise(rise1), .fall(fall1), .changed(changed1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [3:0] eo, input logic [3:0] er,
                        input logic [3:0] ef);
        chk({tag, "_out0"}, out0, eo);
        chk({tag, "_rise0"}, rise0, er);
        chk({tag, "_fall0"}, fall0, ef);
        chk({tag, "_chg0"}, changed0, |(er | ef));
    endtask

    task automatic chk1(input string tag, input logic [3:0] eo, input logic [3:0] er,
                        input logic [3:0] ef);
        chk({tag, "_out1"}, out1, eo);
        chk({tag, "_rise1"}, rise1, er);
        chk({tag, "_fall1"}, fall1, ef);
        chk({tag, "_chg1"}, changed1, |(er | ef));
    endtask

    initial begin
        logic [3:0] eo, er, ef, prev;
        int idx;

        // reset held: INIT on outputs, no pulses
        repeat (3) step();
        chk0("rst", 4'h0, 4'h0, 4'h0);
        chk1("rst", 4'hF, 4'h0, 4'h0);

        // release with dut0 seeing 0101 and dut1 seeing 0000 against INIT=1111
        reset_n = 1'b1;
        in0 = 4'b0101;
        in1 = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk0($sformatf("up_e%0d", k), (k >= LAT0) ? 4'b0101 : 4'b0000,
                 (k == LAT0) ? 4'b0101 : 4'b0000, 4'b0000);
            chk1($sformatf("up_e%0d", k), (k >= LAT1) ? 4'b0000 : 4'b1111,
                 4'b0000, (k == LAT1) ? 4'b1111 : 4'b0000);
        end

        // simultaneous fall on bit0 and rise on bit1
        in0 = 4'b0110;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk0($sformatf("mix_e%0d", k), (k >= LAT0) ? 4'b0110 : 4'b0101,
                 (k == LAT0) ? 4'b0010 : 4'b0000, (k == LAT0) ? 4'b0001 : 4'b0000);
        end

        // 3-cycle high glitch on bit3
        for (int k = 1; k <= 10; k++) begin
            in0 = (k <= 3) ? 4'b1110 : 4'b0110;
            step();
            if (FILT) begin
                eo = 4'b0110; er = 4'b0000; ef = 4'b0000;
            end else begin
                eo = (k >= 2 && k <= 4) ? 4'b1110 : 4'b0110;
                er = (k == 2) ? 4'b1000 : 4'b0000;
                ef = (k == 5) ? 4'b1000 : 4'b0000;
            end
            chk0($sformatf("gl3_e%0d", k), eo, er, ef);
        end

        // 1-cycle low glitch on bit2: back-to-back pulses when unfiltered
        for (int k = 1; k <= 6; k++) begin
            in0 = (k == 1) ? 4'b0010 : 4'b0110;
            step();
            if (FILT) begin
                eo = 4'b0110; er = 4'b0000; ef = 4'b0000;
            end else begin
                eo = (k == 2) ? 4'b0010 : 4'b0110;
                er = (k == 3) ? 4'b0100 : 4'b0000;
                ef = (k == 2) ? 4'b0100 : 4'b0000;
            end
            chk0($sformatf("gl2_e%0d", k), eo, er, ef);
        end

        // reset mid-count: asynchronous return to INIT, no pulse afterwards
        in0 = 4'b0111;
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk0("arst", 4'h0, 4'h0, 4'h0);
        chk1("arst", 4'hF, 4'h0, 4'h0);
        in0 = 4'b0000;
        in1 = 4'b1111;
        repeat (2) step();
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk0($sformatf("post_e%0d", k), 4'h0, 4'h0, 4'h0);
            chk1($sformatf("post_e%0d", k), 4'hF, 4'h0, 4'h0);
        end

        // bit2 of dut1 toggles every 3 cycles: pure delay of LAT1 edges
        for (int e = 1; e <= 24; e++) begin
            hist[e] = (((e - 1) / 3) % 2 == 0) ? 4'hB : 4'hF;
            in1 = hist[e];
            step();
            idx  = e - LAT1 + 1;
            eo   = (idx >= 1) ? hist[idx] : 4'hF;
            prev = (idx >= 2) ? hist[idx-1] : 4'hF;
            chk1($sformatf("tog_e%0d", e), eo, eo & ~prev, ~eo & prev);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wca_synch_filter.md
WCA_SYNCH_FILTER -- requirements
Module: wca_synch_filter

Interface
REQ-001 Parameter WIDTH, default 1: number of independent single-bit channels, range 1..32.
REQ-002 Parameter STAGES, default 2: synchronizer flops per channel, range 2..4.
REQ-003 Parameter FILTER_LEN, default 4: consecutive synchronized cycles a new level must hold before it is accepted, range 1..256.
REQ-004 Parameter INIT, default all-zero: WIDTH-bit reset value of the synchronizer chain and out.
REQ-005 The clock port SHALL be: clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 The reset port SHALL be: reset_n  input  1  asynchronous, active-low reset.
REQ-007 in  input  WIDTH  asynchronous level inputs, one per channel.
REQ-008 out  output  WIDTH  synchronized level (filtered when the filter is compiled in), registered.
REQ-009 rise  output  WIDTH  one-cycle pulse per channel on out 0->1, registered.
REQ-010 fall  output  WIDTH  one-cycle pulse per channel on out 1->0, registered.
REQ-011 changed  output  1  one-cycle pulse when any bit of rise or fall is set, registered.

Function
REQ-012 Each channel SHALL pass in[i] through a STAGES-deep flop chain; the last stage is the synchronized level s[i].
REQ-013 Channels SHALL be fully independent; no channel's state affects another's out, rise or fall.
REQ-014 Unfiltered: out[i] SHALL equal s[i], i.e. a level change reaches out on the STAGES-th rising edge, counting the first edge that samples the new value as edge 1.
REQ-015 Filtered: each channel SHALL hold a counter cnt[i] of width clog2(FILTER_LEN), minimum 1 bit.
REQ-016 Filtered: when s[i] == out[i], cnt[i] SHALL clear to 0 on the next edge.
REQ-017 Filtered: when s[i] != out[i] and cnt[i] < FILTER_LEN-1, cnt[i] SHALL increment.
REQ-018 Filtered: when s[i] != out[i] and cnt[i] == FILTER_LEN-1, out[i] SHALL take s[i] and cnt[i] SHALL clear on the same edge.
REQ-019 Filtered latency: a clean level change SHALL reach out on edge STAGES+FILTER_LEN; with FILTER_LEN=1 this is edge STAGES+1.
REQ-020 A glitch on s[i] shorter than FILTER_LEN cycles SHALL leave out[i], rise[i] and fall[i] unchanged and SHALL restart the count.
REQ-021 The counter SHALL never wrap; it holds at most FILTER_LEN-1.
REQ-022 rise[i] or fall[i] SHALL assert on the same edge out[i] changes, for exactly one cycle, and never both at once.
REQ-023 Back-to-back transitions on consecutive accepted edges SHALL each produce their own pulse.
REQ-024 changed SHALL assert on the same edge as any rise or fall bit, for one cycle.

Reset
REQ-025 While reset_n is low, all synchronizer flops and out SHALL equal INIT, and rise, fall, changed and all counters SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-count or mid-pulse SHALL discard the pending transition with no pulse emitted.
REQ-027 After release, an input equal to INIT SHALL produce no pulse; an input differing from INIT SHALL be treated as a normal transition with the latency above.

Configuration
REQ-028 Macro WCA_SYNCH_FILTER_EN defined: filter counters per REQ-015..REQ-021 are compiled in and FILTER_LEN is honoured.
REQ-029 WCA_SYNCH_FILTER_EN undefined: no counters exist, FILTER_LEN is ignored, and out follows REQ-014; pulses and reset behaviour are unchanged.

Verification
REQ-030 WIDTH=4, STAGES=2, filter off, INIT=0: in 0->4'b0101 after reset -> out=0101 on edge 2, with rise=0101 and changed=1 for one cycle.
REQ-031 Filter on, FILTER_LEN=4, STAGES=2: in[0] 0->1 held -> out[0]=1 and rise[0]=1 on edge 6, none earlier.
REQ-032 Filter on, FILTER_LEN=4: in[0] 3-cycle high glitch -> out, rise, fall and changed stay 0 throughout.
REQ-033 Filter on: reset_n pulsed low while cnt[0]=2 -> out=INIT immediately, no pulse after release while in equals INIT.
REQ-034 INIT=4'b1111, in=4'b0000 at reset release, filter off, STAGES=3 -> fall=1111 and changed=1 on edge 3, then all 0.
REQ-035 Filter on, FILTER_LEN=1: in[2] toggles every 3 cycles -> alternating rise[2]/fall[2] single-cycle pulses, each 3 edges after the toggle.
